// File: rtl/odometer_beat_counter_if.sv
// Measurement-side bundle of the odometer beat counter: async trigger and
// stressed oscillator in, measurement result and status out.
interface odometer_beat_counter_if #(
    parameter int CNT_W = 16
);
    logic             meas_trig;
    logic             rosc_stress;
    logic [CNT_W-1:0] count;
    logic             done;
    logic             busy;
    logic             ovf;

    modport master (
        output meas_trig,
        output rosc_stress,
        input  count,
        input  done,
        input  busy,
        input  ovf
    );

    modport slave (
        input  meas_trig,
        input  rosc_stress,
        output count,
        output done,
        output busy,
        output ovf
    );
endinterface

// File: rtl/odometer_beat_counter.sv
// Counts reference-oscillator cycles spanning NUM_BEATS periods of the beat
// between the reference and stressed ring oscillators, with glitch filtering.
module odometer_beat_counter #(
    parameter int CNT_W     = 16,
    parameter int NUM_BEATS = 4,
    parameter int FILT      = 2
) (
    input  logic                   rosc_ref_i,
    input  logic                   resetb_i,
    odometer_beat_counter_if.slave bus
);

    localparam int               N_SYNC  = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [3:0]       BEATS_L = 4'(NUM_BEATS);
    localparam logic [2:0]       FILT_L  = 3'(FILT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_COUNT,
        ST_DONE
    } state_t;

    // Bit 0 carries the trigger, bit 1 the stressed oscillator.
    logic [N_SYNC-1:0] async_in;
    logic [N_SYNC-1:0] sync_out;

    assign async_in = {bus.rosc_stress, bus.meas_trig};

    for (genvar gi = 0; gi < N_SYNC; gi++) begin : g_sync
        logic s1_q;
        logic s2_q;

        always_ff @(posedge rosc_ref_i or negedge resetb_i) begin
            if (!resetb_i) begin
                s1_q <= 1'b0;
                s2_q <= 1'b0;
            end else begin
                s1_q <= async_in[gi];
                s2_q <= s1_q;
            end
        end

        assign sync_out[gi] = s2_q;
    end

    logic trig_d_q;
    logic trig_evt;
    logic beat_raw;

    assign beat_raw = sync_out[1];
    assign trig_evt = sync_out[0] & ~trig_d_q;

    always_ff @(posedge rosc_ref_i or negedge resetb_i) begin
        if (!resetb_i) begin
            trig_d_q <= 1'b0;
        end else begin
            trig_d_q <= sync_out[0];
        end
    end

    // Run length of samples disagreeing with the accepted level; any
    // agreeing sample restarts the run.
    logic [2:0] run_q;
    logic       beat_filt_q;
    logic       beat_prev_q;
    logic       beat_evt;

    always_ff @(posedge rosc_ref_i or negedge resetb_i) begin
        if (!resetb_i) begin
            run_q       <= '0;
            beat_filt_q <= 1'b0;
            beat_prev_q <= 1'b0;
        end else begin
            beat_prev_q <= beat_filt_q;
            if (beat_raw == beat_filt_q) begin
                run_q <= '0;
            end else if (run_q + 3'd1 == FILT_L) begin
                beat_filt_q <= beat_raw;
                run_q       <= '0;
            end else begin
                run_q <= run_q + 3'd1;
            end
        end
    end

    assign beat_evt = beat_filt_q & ~beat_prev_q;

    state_t           state_q;
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] cyc_d;
    logic [3:0]       beat_cnt_q;
    logic [3:0]       beat_cnt_d;
    logic [CNT_W-1:0] count_q;
    logic             done_q;
    logic             busy_q;
    logic             ovf_q;
    logic             cyc_sat;

    assign cyc_d      = cyc_q + CNT_W'(1);
    assign beat_cnt_d = beat_cnt_q + 4'd1;
    assign cyc_sat    = (cyc_q == CNT_MAX);

    // A trigger restarts from any state; saturation outranks a final beat.
    always_ff @(posedge rosc_ref_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q    <= ST_IDLE;
            cyc_q      <= '0;
            beat_cnt_q <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (trig_evt) begin
            state_q    <= ST_ARM;
            cyc_q      <= '0;
            beat_cnt_q <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b1;
            ovf_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_ARM: begin
                    if (cyc_sat) begin
                        state_q <= ST_DONE;
                        count_q <= CNT_MAX;
                        ovf_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (beat_evt) begin
                        state_q    <= ST_COUNT;
                        cyc_q      <= '0;
                        beat_cnt_q <= '0;
                    end else begin
                        cyc_q <= cyc_d;
                    end
                end
                ST_COUNT: begin
                    if (cyc_sat) begin
                        state_q <= ST_DONE;
                        count_q <= CNT_MAX;
                        ovf_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (beat_evt && (beat_cnt_d == BEATS_L)) begin
                        state_q    <= ST_DONE;
                        beat_cnt_q <= beat_cnt_d;
                        count_q    <= cyc_d;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        cyc_q <= cyc_d;
                        if (beat_evt) begin
                            beat_cnt_q <= beat_cnt_d;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.count = count_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_odometer_beat_counter.sv
// Three counter configurations share one stimulus stream; a timestamp-based
// model predicts every output on every cycle.
module tb_odometer_beat_counter;

    localparam int NONE = -100;
    localparam int MAXV [3] = '{65535, 255, 65535};
    localparam int NBV  [3] = '{4, 4, 1};
    localparam int FV   [3] = '{2, 2, 7};

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic trig   = 1'b0;
    logic stress = 1'b0;

    always #5 clk = ~clk;

    odometer_beat_counter_if #(.CNT_W(16)) if_a ();
    odometer_beat_counter_if #(.CNT_W(8))  if_b ();
    odometer_beat_counter_if #(.CNT_W(16)) if_c ();

    assign if_a.meas_trig   = trig;
    assign if_a.rosc_stress = stress;
    assign if_b.meas_trig   = trig;
    assign if_b.rosc_stress = stress;
    assign if_c.meas_trig   = trig;
    assign if_c.rosc_stress = stress;

    odometer_beat_counter #(.CNT_W(16), .NUM_BEATS(4), .FILT(2)) dut_a (
        .rosc_ref_i(clk), .resetb_i(rst_n), .bus(if_a));
    odometer_beat_counter #(.CNT_W(8),  .NUM_BEATS(4), .FILT(2)) dut_b (
        .rosc_ref_i(clk), .resetb_i(rst_n), .bus(if_b));
    odometer_beat_counter #(.CNT_W(16), .NUM_BEATS(1), .FILT(7)) dut_c (
        .rosc_ref_i(clk), .resetb_i(rst_n), .bus(if_c));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Trigger and beat levels are seen through fixed pipelines; measurement
    // results come from edge timestamps rather than running counters.
    bit tr_h [3];      // trigger samples of edges k-1, k-2, k-3
    bit sy   [2];      // stress samples of edges k-1, k-2
    bit win  [7];      // filter input samples, newest first
    int edge_k = 0;
    int mode   [3];    // 0 idle, 1 arming, 2 counting, 3 done
    int a_edge [3];
    int e0     [3];
    int beats  [3];
    int m_cnt  [3];
    bit m_ovf  [3];
    bit fcur   [3];
    bit fprev  [3];

    function automatic void model_reset();
        for (int j = 0; j < 3; j++) tr_h[j] = 1'b0;
        for (int j = 0; j < 2; j++) sy[j] = 1'b0;
        for (int j = 0; j < 7; j++) win[j] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mode[i] = 0; beats[i] = 0; m_cnt[i] = 0; m_ovf[i] = 1'b0;
            fcur[i] = 1'b0; fprev[i] = 1'b0; a_edge[i] = 0; e0[i] = 0;
        end
    endfunction

    function automatic void model_step();
        bit trig_now;
        bit ev [3];
        bit all_opp;
        if (!rst_n) begin
            model_reset();
            return;
        end
        edge_k++;
        trig_now = tr_h[1] & ~tr_h[2];
        for (int i = 0; i < 3; i++) ev[i] = fcur[i] & ~fprev[i];
        for (int i = 0; i < 3; i++) begin
            if (trig_now) begin
                mode[i] = 1; a_edge[i] = edge_k; beats[i] = 0;
                m_cnt[i] = 0; m_ovf[i] = 1'b0;
            end else if (mode[i] == 1) begin
                if (edge_k - a_edge[i] == MAXV[i] + 1) begin
                    mode[i] = 3; m_cnt[i] = MAXV[i]; m_ovf[i] = 1'b1;
                end else if (ev[i]) begin
                    mode[i] = 2; e0[i] = edge_k; beats[i] = 0;
                end
            end else if (mode[i] == 2) begin
                if (edge_k - e0[i] == MAXV[i] + 1) begin
                    mode[i] = 3; m_cnt[i] = MAXV[i]; m_ovf[i] = 1'b1;
                end else if (ev[i]) begin
                    beats[i]++;
                    if (beats[i] == NBV[i]) begin
                        mode[i] = 3; m_cnt[i] = edge_k - e0[i];
                    end
                end
            end
        end
        for (int j = 6; j > 0; j--) win[j] = win[j-1];
        win[0] = sy[1];
        for (int i = 0; i < 3; i++) begin
            fprev[i] = fcur[i];
            all_opp = 1'b1;
            for (int j = 0; j < FV[i]; j++) if (win[j] == fcur[i]) all_opp = 1'b0;
            if (all_opp) fcur[i] = ~fcur[i];
        end
        tr_h[2] = tr_h[1]; tr_h[1] = tr_h[0]; tr_h[0] = trig;
        sy[1] = sy[0]; sy[0] = stress;
    endfunction

    // ---------------- per-cycle compare ----------------
    task automatic cmp_inst(input int i, input int cnt, input bit d, input bit b, input bit o);
        string tag;
        tag = (i == 0) ? "a" : (i == 1) ? "b" : "c";
        check({tag, ".count"}, cnt, m_cnt[i]);
        check({tag, ".done"}, d, mode[i] == 3);
        check({tag, ".busy"}, b, (mode[i] == 1) || (mode[i] == 2));
        check({tag, ".ovf"}, o, m_ovf[i]);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cmp_inst(0, int'(if_a.count), if_a.done, if_a.busy, if_a.ovf);
            cmp_inst(1, int'(if_b.count), if_b.done, if_b.busy, if_b.ovf);
            cmp_inst(2, int'(if_c.count), if_c.done, if_c.busy, if_c.ovf);
        end
    end

    // ---------------- stimulus ----------------
    int wave_t = 0;
    bit noise  = 1'b0;

    task automatic step(input bit t, input int per, input int hi, input bit glitch);
        int ph;
        bit s;
        ph = wave_t % per;
        s  = (ph < hi);
        if (glitch && ph == hi + (per - hi) / 2) s = 1'b1;
        if (noise && $urandom_range(0, 40) == 0) s = ~s;
        trig   = t;
        stress = s;
        wave_t++;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic run(input int n, input int per, input int hi, input bit glitch,
                       input int t1, input int t2);
        for (int c = 0; c < n; c++)
            step((c >= t1 && c < t1 + 3) || (c >= t2 && c < t2 + 3), per, hi, glitch);
    endtask

    task automatic reset_pulse(input int hold);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst.a_outputs", {if_a.count, if_a.done, if_a.busy, if_a.ovf}, 0);
        check("rst.b_outputs", {if_b.count, if_b.done, if_b.busy, if_b.ovf}, 0);
        check("rst.c_outputs", {if_c.count, if_c.done, if_c.busy, if_c.ovf}, 0);
        for (int c = 0; c < hold; c++) step(1'b0, 1, 0, 1'b0);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int per, hi, t1, t2;
        bit gl;
        model_reset();
        @(negedge clk);
        for (int c = 0; c < 3; c++) step(1'b0, 1, 0, 1'b0);
        check("reset.busy", if_a.busy, 0);
        check("reset.count", if_a.count, 0);
        #2;
        rst_n = 1'b1;
        run(10, 1, 0, 1'b0, NONE, NONE);

        // Nominal 100-cycle beat, with trigger-to-BUSY latency pinned.
        wave_t = 0;
        step(1'b1, 100, 50, 1'b0);
        check("lat.edge1_busy", if_a.busy, 0);
        step(1'b1, 100, 50, 1'b0);
        check("lat.edge2_busy", if_a.busy, 0);
        step(1'b1, 100, 50, 1'b0);
        check("lat.edge3_busy", if_a.busy, 1);
        run(700, 100, 50, 1'b0, NONE, NONE);
        check("nom.a_count", if_a.count, 400);
        check("nom.a_done", if_a.done, 1);
        check("nom.a_ovf", if_a.ovf, 0);
        check("nom.model_a", m_cnt[0], 400);
        check("nom.b_ovf_count", {if_b.ovf, if_b.count}, {1'b1, 8'd255});
        check("nom.c_count", if_c.count, 100);

        // One-cycle glitches in the low phase are filtered out.
        wave_t = 0;
        run(720, 100, 50, 1'b1, 5, NONE);
        check("glitch.a_count", if_a.count, 400);
        check("glitch.c_count", if_c.count, 100);

        // No beat at all: the 8-bit counter saturates 256 cycles after arming.
        run(20, 1, 0, 1'b0, NONE, NONE);
        for (int c = 0; c < 3; c++) step(1'b1, 1, 0, 1'b0);
        for (int c = 0; c < 255; c++) step(1'b0, 1, 0, 1'b0);
        check("sat.b_done_early", if_b.done, 0);
        step(1'b0, 1, 0, 1'b0);
        check("sat.b_done", if_b.done, 1);
        check("sat.b_count", if_b.count, 255);
        check("sat.b_ovf", if_b.ovf, 1);
        check("sat.model_b", m_cnt[1], 255);

        // Retrigger after two counted beats restarts cleanly.
        wave_t = 0;
        run(1000, 100, 50, 1'b0, 5, 350);
        check("retrig.a_count", if_a.count, 400);
        check("retrig.a_ovf", if_a.ovf, 0);

        // Reset in the middle of a measurement, then no spontaneous restart.
        wave_t = 0;
        run(250, 100, 50, 1'b0, 5, NONE);
        check("midrst.a_busy", if_a.busy, 1);
        reset_pulse(3);
        run(300, 100, 50, 1'b0, NONE, NONE);
        check("postrst.a_busy", if_a.busy, 0);
        check("postrst.a_done", if_a.done, 0);

        // Period 37: single-beat config with the long filter still reads 37.
        wave_t = 0;
        run(300, 37, 18, 1'b0, 3, NONE);
        check("p37.c_count", if_c.count, 37);
        check("p37.a_count", if_a.count, 148);
        check("p37.b_count", if_b.count, 148);
        check("p37.model_c", m_cnt[2], 37);

        // Randomized waveforms, glitches, triggers and resets.
        for (int it = 0; it < 12; it++) begin
            per   = $urandom_range(16, 120);
            hi    = $urandom_range(1, per - 1);
            gl    = 1'($urandom_range(0, 1));
            noise = 1'($urandom_range(0, 1));
            t1    = $urandom_range(0, 50);
            t2    = ($urandom_range(0, 2) == 0) ? $urandom_range(60, 400) : NONE;
            run(per * 6 + 200, per, hi, gl, t1, t2);
            if ($urandom_range(0, 3) == 0) reset_pulse($urandom_range(1, 4));
        end
        noise = 1'b0;
        run(5, 1, 0, 1'b0, NONE, NONE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/odometer_beat_counter.md
ODOMETER_BEAT_COUNTER -- requirements
Module: odometer_beat_counter

Interface
REQ-001 Parameter CNT_W, default 16: width of the cycle counter and COUNT.
REQ-002 Parameter NUM_BEATS, default 4: number of beat periods accumulated per measurement, legal range 1..15.
REQ-003 Parameter FILT, default 2: consecutive equal samples needed to accept a beat level change, legal range 1..7.
REQ-004 ROSC_REF  input  1: the only clock; reference ring-oscillator output; all flops on its rising edge.
REQ-005 RESETB  input  1: reset, asynchronous, active-low.
REQ-006 ROSC_STRESS  input  1: stressed ring-oscillator output, asynchronous to ROSC_REF.
REQ-007 MEAS_TRIG  input  1: asynchronous measurement request; each rising edge starts a measurement.
REQ-008 COUNT  output  CNT_W: ROSC_REF cycles spanning NUM_BEATS beat periods.
REQ-009 DONE  output  1: level; COUNT/OVF valid.
REQ-010 BUSY  output  1: level; measurement in progress.
REQ-011 OVF  output  1: level; cycle counter saturated, COUNT invalid.

Function
REQ-012 MEAS_TRIG passes a 2-flop synchronizer plus an edge-detect flop; trig_evt is a 1-cycle pulse on a synchronized 0->1 transition.
REQ-013 ROSC_STRESS passes a 2-flop synchronizer producing beat_raw, i.e. the beat waveform sampled by ROSC_REF.
REQ-014 Filter: beat_filt changes to beat_raw only after beat_raw has differed from beat_filt for FILT consecutive cycles; the run counter clears on any sample equal to beat_filt.
REQ-015 beat_evt is a 1-cycle pulse on each 0->1 transition of beat_filt.
REQ-016 The FSM has the states IDLE, ARM, COUNT, DONE; IDLE after reset.
REQ-017 IDLE -> ARM on trig_evt; cyc_cnt, beat_cnt, COUNT, OVF, DONE clear to 0.
REQ-018 ARM: cyc_cnt increments by 1 each cycle; on beat_evt -> COUNT with cyc_cnt=0 and beat_cnt=0.
REQ-019 COUNT: cyc_cnt increments by 1 each cycle; each beat_evt increments beat_cnt.
REQ-020 COUNT -> DONE on the beat_evt that makes beat_cnt equal NUM_BEATS; COUNT loads cyc_cnt+1 in that cycle, so the value equals the cycles elapsed from the first beat_evt to the final beat_evt.
REQ-021 Saturation: in ARM or COUNT, when cyc_cnt equals 2^CNT_W-1 -> DONE with OVF=1 and COUNT=2^CNT_W-1; cyc_cnt never wraps.
REQ-022 Simultaneous saturation and final beat_evt: OVF path wins.
REQ-023 DONE: DONE=1, BUSY=0; COUNT/OVF hold until the next trig_evt.
REQ-024 BUSY=1 exactly in ARM and COUNT.
REQ-025 trig_evt in ARM, COUNT or DONE restarts: -> ARM with the same clears as REQ-017, abandoning the current measurement.
REQ-026 Beat events in IDLE and DONE are ignored.
REQ-027 Latency: BUSY rises on the 3rd ROSC_REF rising edge after MEAS_TRIG rises setup-clean; DONE rises on the edge after the final beat_evt cycle.

Reset
REQ-028 RESETB low asynchronously forces IDLE, COUNT=0, DONE=0, BUSY=0, OVF=0, clears all synchronizer, filter and counter flops; release is synchronous to ROSC_REF through the existing flops, no extra requirement.
REQ-029 Reset asserted mid-measurement discards it; after release, no measurement starts without a fresh MEAS_TRIG rising edge.

Verification
REQ-030 MEAS_TRIG rise, beat_raw period 100 cycles (50/50), NUM_BEATS=4, FILT=2 -> DONE=1, COUNT=400, OVF=0.
REQ-031 As REQ-030 plus 1-cycle glitches on beat_raw mid-low phase -> no extra beat_evt, COUNT=400.
REQ-032 ROSC_STRESS held at 0 after trigger, CNT_W=8 -> OVF=1, COUNT=255, DONE=1 at 256 cycles after ARM entry.
REQ-033 Second MEAS_TRIG rise during COUNT after 2 beats -> restart in ARM, final COUNT=400, not a mix.
REQ-034 RESETB pulsed low during COUNT -> all outputs 0 immediately; held in IDLE until the next MEAS_TRIG rise.
REQ-035 NUM_BEATS=1, beat period 37 -> COUNT=37; beat period 37 with FILT=7 -> COUNT=37 (fixed filter delay cancels).
